// File: rtl/seq_divider.sv
// Multi-cycle restoring divider for DIV/DIVU: one quotient bit per cycle,
// sign fix-up in a separate cycle, start/done handshake with busy.
module seq_divider #(
   parameter int n = 32
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         start,
   input  logic         is_signed,
   input  logic [n-1:0] A,
   input  logic [n-1:0] B,
   output logic         busy,
   output logic         done,
   output logic         div_by_zero,
   output logic [n-1:0] Q,
   output logic [n-1:0] R
);

   localparam int CW = (n > 1) ? $clog2(n) : 1;

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_CALC = 2'd1;
   localparam logic [1:0] S_FIX  = 2'd2;
   localparam logic [1:0] S_DONE = 2'd3;

   logic [1:0]    r_state;
   logic [CW-1:0] r_cnt;
   logic [n-1:0]  r_rem;
   logic [n-1:0]  r_quo;
   logic [n-1:0]  r_bmag;
   logic          r_neg_q;
   logic          r_neg_r;
   logic [n-1:0]  r_q;
   logic [n-1:0]  r_r;
   logic          r_dbz;
   logic          r_busy;
   logic          r_done;

   logic [n-1:0]  w_a_mag;
   logic [n-1:0]  w_b_mag;
   logic [n:0]    w_shift;
   logic [n:0]    w_trial;
   logic          w_fits;

   assign w_a_mag = (is_signed && A[n-1]) ? -A : A;
   assign w_b_mag = (is_signed && B[n-1]) ? -B : B;

   // rem < |B| always holds, so the n+1-bit difference cannot overflow and
   // its MSB is the borrow.
   assign w_shift = {r_rem, r_quo[n-1]};
   assign w_trial = w_shift - {1'b0, r_bmag};
   assign w_fits  = ~w_trial[n];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
         r_cnt   <= '0;
         r_rem   <= '0;
         r_quo   <= '0;
         r_bmag  <= '0;
         r_neg_q <= 1'b0;
         r_neg_r <= 1'b0;
         r_q     <= '0;
         r_r     <= '0;
         r_dbz   <= 1'b0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
      end else begin
         // Status outputs trail the state by one cycle.
         r_busy <= (r_state != S_IDLE);
         r_done <= (r_state == S_DONE);
         case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_dbz   <= (B == '0);
                  r_neg_q <= is_signed & (A[n-1] ^ B[n-1]);
                  r_neg_r <= is_signed & A[n-1];
                  if (B == '0) begin
                     r_q     <= '1;
                     r_r     <= A;
                     r_state <= S_DONE;
                  end else begin
                     r_quo   <= w_a_mag;
                     r_bmag  <= w_b_mag;
                     r_rem   <= '0;
                     r_cnt   <= CW'(n - 1);
                     r_state <= S_CALC;
                  end
               end
            end
            S_CALC: begin
               r_rem <= w_fits ? w_trial[n-1:0] : w_shift[n-1:0];
               r_quo <= {r_quo[n-2:0], w_fits};
               if (r_cnt == '0) r_state <= S_FIX;
               else             r_cnt   <= r_cnt - 1'b1;
            end
            S_FIX: begin
               r_q     <= r_neg_q ? -r_quo : r_quo;
               r_r     <= r_neg_r ? -r_rem : r_rem;
               r_state <= S_DONE;
            end
            S_DONE:  r_state <= S_IDLE;
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign busy        = r_busy;
   assign done        = r_done;
   assign div_by_zero = r_dbz;
   assign Q           = r_q;
   assign R           = r_r;

endmodule

// File: tb/tb_seq_divider.sv
// Self-checking bench for seq_divider: directed table, handshake/reset
// corner sequences and randomized operands against an arithmetic model.
module tb_seq_divider;

   localparam int N = 32;

   logic          clk;
   logic          rst_n;
   logic          start;
   logic          is_signed;
   logic [N-1:0]  A;
   logic [N-1:0]  B;
   logic          busy;
   logic          done;
   logic          div_by_zero;
   logic [N-1:0]  Q;
   logic [N-1:0]  R;

   int n_cmp = 0;
   int n_bad = 0;

   seq_divider #(.n(N)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .start       (start),
      .is_signed   (is_signed),
      .A           (A),
      .B           (B),
      .busy        (busy),
      .done        (done),
      .div_by_zero (div_by_zero),
      .Q           (Q),
      .R           (R)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] a;
      logic [31:0] b;
      logic        s;
      logic [31:0] eq;
      logic [31:0] er;
      logic        ez;
   } vec_t;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Reference: plain integer division semantics plus the two special cases.
   function automatic void ref_div(input logic [31:0] a, input logic [31:0] b, input logic s,
                                   output logic [31:0] q, output logic [31:0] r, output logic z);
      z = (b == 32'd0);
      if (b == 32'd0) begin
         q = 32'hFFFF_FFFF;
         r = a;
      end else if (s) begin
         if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            q = a;
            r = 32'd0;
         end else begin
            q = $signed(a) / $signed(b);
            r = $signed(a) % $signed(b);
         end
      end else begin
         q = a / b;
         r = a % b;
      end
   endfunction

   // Called #1 after a rising edge. poke_at >= 0 pulses start (A=B=1) in the
   // cycle after edge poke_at, i.e. it is sampled at edge poke_at+1.
   task automatic run_div(input logic [31:0] a, input logic [31:0] b, input logic s,
                          input int poke_at,
                          output logic [31:0] q, output logic [31:0] r, output logic z,
                          output int lat, output int bcnt);
      A = a; B = b; is_signed = s; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      A = $urandom; B = $urandom; is_signed = ~s;
      lat = 0; bcnt = 0;
      while (done !== 1'b1 && lat < 100) begin
         if (busy === 1'b1) bcnt++;
         if (lat == poke_at) begin
            start = 1'b1; A = 32'd1; B = 32'd1;
         end else begin
            start = 1'b0;
         end
         @(posedge clk); #1;
         lat++;
      end
      if (busy === 1'b1) bcnt++;
      start = 1'b0;
      q = Q; r = R; z = div_by_zero;
      @(posedge clk); #1;
      chk("done_pulse_width", {31'd0, done}, 32'd0);
      chk("busy_after_done", {31'd0, busy}, 32'd0);
      chk("q_held", Q, q);
   endtask

   task automatic check_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                           input logic s, input int poke_at,
                           input logic [31:0] eq, input logic [31:0] er, input logic ez);
      logic [31:0] q, r;
      logic        z;
      int          lat, bcnt, elat;
      run_div(a, b, s, poke_at, q, r, z, lat, bcnt);
      elat = ez ? 1 : N + 2;
      chk({tag, "_Q"}, q, eq);
      chk({tag, "_R"}, r, er);
      chk({tag, "_dbz"}, {31'd0, z}, {31'd0, ez});
      chk({tag, "_latency"}, lat, elat);
      chk({tag, "_busy_cycles"}, bcnt, elat);
   endtask

   vec_t tbl[10];

   initial begin
      logic [31:0] a, b, eq, er;
      logic        s, ez;

      tbl[0] = '{32'd42566,      32'd15211,      1'b0, 32'd2,          32'd12144,      1'b0};
      tbl[1] = '{32'd5985,       32'd785,        1'b0, 32'd7,          32'd490,        1'b0};
      tbl[2] = '{32'hFFFF_FFF9,  32'd2,          1'b1, 32'hFFFF_FFFD,  32'hFFFF_FFFF,  1'b0};
      tbl[3] = '{32'd785,        32'd0,          1'b1, 32'hFFFF_FFFF,  32'd785,        1'b1};
      tbl[4] = '{32'd785,        32'd0,          1'b0, 32'hFFFF_FFFF,  32'd785,        1'b1};
      tbl[5] = '{32'h8000_0000,  32'hFFFF_FFFF,  1'b1, 32'h8000_0000,  32'd0,          1'b0};
      tbl[6] = '{32'd7,          32'hFFFF_FFFE,  1'b1, 32'hFFFF_FFFD,  32'd1,          1'b0};
      tbl[7] = '{32'hFFFF_FFF9,  32'hFFFF_FFFE,  1'b1, 32'd3,          32'hFFFF_FFFF,  1'b0};
      tbl[8] = '{32'hFFFF_FFFF,  32'd1,          1'b0, 32'hFFFF_FFFF,  32'd0,          1'b0};
      tbl[9] = '{32'h8000_0000,  32'hFFFF_FFFF,  1'b0, 32'd0,          32'h8000_0000,  1'b0};

      rst_n = 1'b0; start = 1'b0; is_signed = 1'b0; A = '0; B = '0;
      #1;
      chk("reset_busy", {31'd0, busy}, 32'd0);
      chk("reset_done", {31'd0, done}, 32'd0);
      chk("reset_dbz",  {31'd0, div_by_zero}, 32'd0);
      chk("reset_Q", Q, 32'd0);
      chk("reset_R", R, 32'd0);
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      @(posedge clk); #1;

      foreach (tbl[i])
         check_op($sformatf("vec%0d", i), tbl[i].a, tbl[i].b, tbl[i].s, -1,
                  tbl[i].eq, tbl[i].er, tbl[i].ez);

      // start pulses while busy (CALC) and in the DONE cycle must be ignored
      check_op("poke_calc", 32'd42566, 32'd15211, 1'b0, 5, 32'd2, 32'd12144, 1'b0);
      check_op("poke_done", 32'd5985, 32'd785, 1'b0, N + 1, 32'd7, 32'd490, 1'b0);

      // Reset mid-operation: abandon, clear outputs, no done pulse
      A = 32'd100; B = 32'd7; is_signed = 1'b0; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (10) @(posedge clk);
      #1 rst_n = 1'b0;
      #1;
      chk("midrst_busy", {31'd0, busy}, 32'd0);
      chk("midrst_done", {31'd0, done}, 32'd0);
      chk("midrst_Q", Q, 32'd0);
      chk("midrst_R", R, 32'd0);
      begin
         int seen = 0;
         repeat (3) begin
            @(posedge clk); #1;
            if (done === 1'b1) seen++;
         end
         #1 rst_n = 1'b1;
         repeat (N + 4) begin
            @(posedge clk); #1;
            if (done === 1'b1) seen++;
         end
         chk("midrst_no_done", seen, 0);
      end
      check_op("after_rst", 32'd5985, 32'd785, 1'b0, -1, 32'd7, 32'd490, 1'b0);

      for (int i = 0; i < 150; i++) begin
         a = $urandom;
         case ($urandom_range(0, 7))
            0:       b = 32'd0;
            1, 2:    b = $urandom_range(1, 255);
            3:       b = -$urandom_range(1, 255);
            4:       begin a = 32'h8000_0000; b = $urandom_range(0, 1) ? 32'hFFFF_FFFF : $urandom; end
            default: b = $urandom;
         endcase
         s = 1'($urandom_range(0, 1));
         ref_div(a, b, s, eq, er, ez);
         check_op($sformatf("rnd%0d", i), a, b, s, -1, eq, er, ez);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
